// File: rtl/frame_buffer_if.sv
// Pixel write/read, palette and clear-control bundle for the indexed-colour frame buffer.
// master drives requests (renderers, scan-out, control); slave is the frame buffer.
interface frame_buffer_if #(
  parameter int COORD_W = 11,
  parameter int IDX_W   = 2,
  parameter int COLOR_W = 8
);
  logic               wen;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_drop;
  logic               ren;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [COLOR_W-1:0] rdata;
  logic               rvalid;
  logic               pal_wen;
  logic [IDX_W-1:0]   pal_addr;
  logic [COLOR_W-1:0] pal_data;
  logic               clr_start;
  logic [IDX_W-1:0]   clr_idx;
  logic               busy;

  modport master (
    output wen, wr_x, wr_y, wr_idx,
    output ren, rd_x, rd_y,
    output pal_wen, pal_addr, pal_data,
    output clr_start, clr_idx,
    input  wr_drop, rdata, rvalid, busy
  );

  modport slave (
    input  wen, wr_x, wr_y, wr_idx,
    input  ren, rd_x, rd_y,
    input  pal_wen, pal_addr, pal_data,
    input  clr_start, clr_idx,
    output wr_drop, rdata, rvalid, busy
  );
endinterface

// File: rtl/frame_buffer.sv
// Indexed-colour frame buffer: palette-index storage, run-time palette, two-stage
// read pipeline, range-checked writes and a hardware clear engine.
module frame_buffer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int IDX_W   = 2,
  parameter int COLOR_W = 8,
  parameter int COORD_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  frame_buffer_if.slave   bus
);
  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAL_N  = 2 ** IDX_W;

  // One extra bit so a limit equal to 2^COORD_W is still representable.
  localparam logic [COORD_W:0]  X_LIM = (COORD_W + 1)'(H_RES);
  localparam logic [COORD_W:0]  Y_LIM = (COORD_W + 1)'(V_RES);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(H_RES);

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ROW;
  endfunction

  function automatic logic [COLOR_W-1:0] pal_init(input int unsigned i);
    case (i)
      2:       return COLOR_W'(8'hD0);
      3:       return COLOR_W'(8'h3F);
      default: return '0;
    endcase
  endfunction

  logic [IDX_W-1:0]   mem [DEPTH];
  logic [COLOR_W-1:0] pal [PAL_N];

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [IDX_W-1:0]   fill;
  logic               busy;
  logic               wr_drop;

  logic               s1_valid;
  logic               s1_oor;
  logic [IDX_W-1:0]   s1_idx;
  logic               rvalid;
  logic [COLOR_W-1:0] rdata;

  logic               wr_in;
  logic               rd_in;
  logic               wr_ok;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;

  assign wr_in   = in_range(bus.wr_x, bus.wr_y);
  assign rd_in   = in_range(bus.rd_x, bus.rd_y);
  assign wr_ok   = bus.wen && wr_in && !busy;
  assign wr_addr = wr_in ? pix_addr(bus.wr_x, bus.wr_y) : '0;
  assign rd_addr = rd_in ? pix_addr(bus.rd_x, bus.rd_y) : '0;

  // Storage and stage-1 index capture carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= fill;
    end else if (wr_ok) begin
      mem[wr_addr] <= bus.wr_idx;
    end
    if (bus.ren) begin
      s1_idx <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      fill  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state <= CLEAR;
            fill  <= bus.clr_idx;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PAL_N; i++) begin
        pal[IDX_W'(i)] <= pal_init(i);
      end
    end else if (bus.pal_wen) begin
      pal[bus.pal_addr] <= bus.pal_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop  <= 1'b0;
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      wr_drop  <= bus.wen && (!wr_in || busy);
      s1_valid <= bus.ren;
      if (bus.ren) begin
        s1_oor <= !rd_in;
      end
      rvalid <= s1_valid;
      if (s1_valid) begin
        rdata <= s1_oor ? '0 : pal[s1_idx];
      end
    end
  end

  assign bus.wr_drop = wr_drop;
  assign bus.busy    = busy;
  assign bus.rvalid  = rvalid;
  assign bus.rdata   = rdata;
endmodule

// File: doc/frame_buffer.md
# frame_buffer

Parametrised indexed-colour frame buffer with integrated palette, hardware screen clear and out-of-range protection. It sits between the game-logic sprite/map renderers (write side) and the VGA scan-out timing generator (read side). Pixels are stored as palette indices and converted to display colour through a run-time-writable palette. Every read returns its result with a fixed two-cycle latency and a valid flag.

## Interface
Parameters:
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- IDX_W, 2: palette index width in bits; the palette has 2^IDX_W entries.
- COLOR_W, 8: output colour width (RRRGGGBB at 8).
- COORD_W, 11: width of the x/y coordinate inputs.

Ports:
- clk, in, 1: single clock for all logic.
- rst_n, in, 1: asynchronous, active-low reset.
- wen, in, 1: pixel write request.
- wr_x, in, COORD_W: write x coordinate.
- wr_y, in, COORD_W: write y coordinate.
- wr_idx, in, IDX_W: palette index to store.
- wr_drop, out, 1: one-cycle pulse when a write request is discarded.
- ren, in, 1: pixel read request.
- rd_x, in, COORD_W: read x coordinate.
- rd_y, in, COORD_W: read y coordinate.
- rdata, out, COLOR_W: colour of the pixel that was read.
- rvalid, out, 1: qualifies rdata.
- pal_wen, in, 1: palette entry write.
- pal_addr, in, IDX_W: palette entry selector.
- pal_data, in, COLOR_W: new palette colour.
- clr_start, in, 1: start hardware clear.
- clr_idx, in, IDX_W: fill index, sampled when clr_start is accepted.
- busy, out, 1: high while a clear is in progress.

## Operation
- Storage: H_RES*V_RES words of IDX_W bits. Address = x + H_RES*y, computed at ADDR_W = clog2(H_RES*V_RES) bits. Storage contents are not reset.
- Range check: a coordinate is in range when x < H_RES and y < V_RES.
- Writes:
  - An out-of-range write is discarded and wr_drop pulses.
  - A write while busy=1 is discarded and wr_drop pulses.
  - Otherwise the write is committed on the clock edge.
- Reads:
  - Stage 1 registers the stored index (or the out-of-range flag).
  - Stage 2 registers the palette colour into rdata.
  - An out-of-range read returns rdata = 0 with rvalid = 1.
  - Reads are permitted while busy; they return current memory contents.
- Palette:
  - 2^IDX_W registers of COLOR_W bits.
  - pal_wen writes entry pal_addr at the clock edge.
  - Reset values: entry0 = 0x00, entry1 = 0x00, entry2 = 0xD0, entry3 = 0x3F, all higher entries = 0x00.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start. The FSM latches clr_idx, resets the counter to 0 and sets busy=1.
  - In CLEAR, each cycle writes the latched index at address counter, then increments the counter.
  - After writing address H_RES*V_RES-1, CLEAR -> IDLE and busy returns to 0.
  - clr_start while in CLEAR is ignored; the clear does not restart.
- Reset (async, any state): FSM = IDLE, counter = 0, busy = 0, rvalid = 0, rdata = 0, wr_drop = 0, palette = reset values. A clear interrupted by reset leaves memory partially filled. No recovery is required.

## Timing
- Write: committed at the edge where wen is sampled. A read issued on the following cycle observes the new value.
- Read latency is 2 cycles: ren at edge N gives rdata/rvalid at edge N+2. rvalid is a delayed copy of ren, so back-to-back reads run at full throughput, one per cycle.
- Write and read to the same address on the same edge: the read returns the old value.
- Palette write on the same edge that stage 2 reads that entry: stage 2 uses the old colour. The new colour applies from the next edge.
- wr_drop is registered and pulses on the edge after the rejected request.
- Clear duration: clr_start sampled at edge N sets busy at edge N. Memory writes occur at edges N+1 .. N+H_RES*V_RES. busy falls at edge N+H_RES*V_RES.
- A user write on the same edge that clr_start is accepted is committed, because busy is still 0 when sampled. The clear then overwrites it.

## Test plan
- Reset: assert rst_n=0 mid-run -> rdata=0, rvalid=0, busy=0, wr_drop=0 immediately. After release, palette entry2 reads back as 0xD0 through a pixel holding index 2.
- Write/read latency (H_RES=8, V_RES=4): write idx 3 at (5,2); read (5,2) one cycle later -> rdata=0x3F, rvalid high exactly 2 cycles after ren. Issue 4 consecutive reads -> 4 consecutive rvalid cycles.
- Range check: write at (8,0) and at (0,4) -> a wr_drop pulse for each, and addresses 8 and 32 are not aliased. Read (9,1) -> rdata=0, rvalid=1.
- Clear: clr_start with clr_idx=2 -> busy high for exactly 32 cycles. Writes during busy each pulse wr_drop. Afterwards every pixel reads 0xD0. A second clr_start mid-clear does not extend busy.
- Palette reprogram: set entry1=0xAA in the same cycle a stage-2 lookup of index 1 occurs -> that read returns 0x00, and the next read returns 0xAA.
- Reset mid-clear: drop rst_n at clear cycle 10 -> busy=0 immediately. After release, a new clr_start completes a full 32-cycle clear.
